// File: rtl/mealy_seq_ctrl_pkg.sv
// Shared types and constants for the Mealy FSM sequencer.
package mealy_ctrl_pkg;

  localparam int SYM_W           = 2;
  localparam int DEFAULT_STATE_W = 3;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    WAIT,
    STEP,
    CAPTURE,
    DONE
  } ctrl_state_t;

endpackage

// File: rtl/mealy_seq_ctrl_step_tick_gen.sv
// Step event source: a TICK_DIV auto-step timer or a rising edge of the step button.
module step_tick_gen #(
  parameter int TICK_DIV = 100000000
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic step_mode,
  input  logic step_btn,
  output logic step_evt
);

  localparam int CNT_W = $clog2(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] tick_cnt;
  logic             btn_q;

  // The counter is held at zero outside auto-mode WAIT cycles, so no partial count survives.
  always_ff @(posedge clk) begin
    if (reset) begin
      tick_cnt <= '0;
      btn_q    <= 1'b0;
    end else begin
      btn_q <= step_btn;
      if (!enable || step_mode || tick_cnt == CNT_LAST)
        tick_cnt <= '0;
      else
        tick_cnt <= tick_cnt + CNT_W'(1);
    end
  end

  assign step_evt = enable & (step_mode ? (step_btn & ~btn_q) : (tick_cnt == CNT_LAST));

endmodule

// File: rtl/mealy_seq_ctrl.sv
// Replays a stored 2-bit symbol program into the board's Mealy FSM and
// captures the FSM output bit of every step.
module mealy_seq_ctrl
  import mealy_ctrl_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 100000000,
  parameter int STATE_W  = DEFAULT_STATE_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load_valid,
  input  logic [SYM_W-1:0]       load_sym,
  input  logic                   clear,
  input  logic                   start,
  input  logic                   step_mode,
  input  logic                   step_btn,
  input  logic [STATE_W-1:0]     init_state,
  input  logic                   fsm_out,
  input  logic [STATE_W-1:0]     fsm_state,
  output logic [SYM_W-1:0]       sw_out,
  output logic                   ctrl_out,
  output logic                   fsm_reset,
  output logic [STATE_W-1:0]     state_init,
  output logic                   busy,
  output logic                   done,
  output logic [$clog2(DEPTH):0] len,
  output logic [$clog2(DEPTH):0] idx,
  output logic [DEPTH-1:0]       out_bits,
  output logic [STATE_W-1:0]     final_state
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int IDX_W  = ADDR_W + 1;
  localparam logic [IDX_W-1:0] FULL = IDX_W'(DEPTH);

  ctrl_state_t      state, state_next;
  logic [SYM_W-1:0] prog [DEPTH];
  logic             step_evt;
  logic             last_step;
  logic             can_edit;
  logic             do_load;

  assign last_step = (idx == len - IDX_W'(1));
  assign can_edit  = (state == IDLE) || (state == DONE);
  assign do_load   = (state == IDLE) && load_valid && !clear && (len != FULL);

  step_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .enable    (state == WAIT),
    .step_mode (step_mode),
    .step_btn  (step_btn),
    .step_evt  (step_evt)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (!clear && start && len != '0) state_next = INIT;
      INIT:    state_next = WAIT;
      WAIT:    if (step_evt) state_next = STEP;
      STEP:    state_next = CAPTURE;
      CAPTURE: state_next = last_step ? DONE : WAIT;
      DONE: begin
        if (clear)      state_next = IDLE;
        else if (start) state_next = INIT;
      end
      default: state_next = IDLE;
    endcase
  end

  // The buffer has no reset: len alone decides which entries are meaningful.
  always_ff @(posedge clk) begin
    if (!reset && do_load)
      prog[len[ADDR_W-1:0]] <= load_sym;
  end

  // Outputs are registered from state_next so each pulse lines up with its state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sw_out      <= '0;
      ctrl_out    <= 1'b0;
      fsm_reset   <= 1'b0;
      state_init  <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      len         <= '0;
      idx         <= '0;
      out_bits    <= '0;
      final_state <= '0;
    end else begin
      ctrl_out  <= 1'b0;
      fsm_reset <= 1'b0;
      busy      <= state_next inside {INIT, WAIT, STEP, CAPTURE};
      done      <= (state_next == DONE);
      if (can_edit && clear) begin
        sw_out      <= '0;
        state_init  <= '0;
        len         <= '0;
        idx         <= '0;
        out_bits    <= '0;
        final_state <= '0;
      end else begin
        if (do_load)
          len <= len + IDX_W'(1);
        if (state_next == INIT) begin
          state_init <= init_state;
          fsm_reset  <= 1'b1;
          idx        <= '0;
          out_bits   <= '0;
        end
        if (state_next == STEP) begin
          sw_out   <= prog[idx[ADDR_W-1:0]];
          ctrl_out <= 1'b1;
        end
        if (state == CAPTURE) begin
          out_bits[idx[ADDR_W-1:0]] <= fsm_out;
          if (last_step) final_state <= fsm_state;
          else           idx         <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_mealy_seq_ctrl.sv
// Directed bench for mealy_seq_ctrl driving a small behavioural model of the board FSM.
module tb_mealy_seq_ctrl;

  localparam int DEPTH    = 8;
  localparam int TICK_DIV = 4;
  localparam int STATE_W  = 3;
  localparam int IDX_W    = $clog2(DEPTH) + 1;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               load_valid = 1'b0;
  logic [1:0]         load_sym = '0;
  logic               clear = 1'b0;
  logic               start = 1'b0;
  logic               step_mode = 1'b0;
  logic               step_btn = 1'b0;
  logic [STATE_W-1:0] init_state = '0;
  logic               fsm_out;
  logic [STATE_W-1:0] fsm_state;
  logic [1:0]         sw_out;
  logic               ctrl_out;
  logic               fsm_reset;
  logic [STATE_W-1:0] state_init;
  logic               busy;
  logic               done;
  logic [IDX_W-1:0]   len;
  logic [IDX_W-1:0]   idx;
  logic [DEPTH-1:0]   out_bits;
  logic [STATE_W-1:0] final_state;

  int vec_count = 0;
  int err_count = 0;

  always #5 clk = ~clk;

  mealy_seq_ctrl #(
    .DEPTH    (DEPTH),
    .TICK_DIV (TICK_DIV),
    .STATE_W  (STATE_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_sym    (load_sym),
    .clear       (clear),
    .start       (start),
    .step_mode   (step_mode),
    .step_btn    (step_btn),
    .init_state  (init_state),
    .fsm_out     (fsm_out),
    .fsm_state   (fsm_state),
    .sw_out      (sw_out),
    .ctrl_out    (ctrl_out),
    .fsm_reset   (fsm_reset),
    .state_init  (state_init),
    .busy        (busy),
    .done        (done),
    .len         (len),
    .idx         (idx),
    .out_bits    (out_bits),
    .final_state (final_state)
  );

  // Board FSM model: next = 0 on symbol 0, else (state ^ sym<<1) with bit0 cleared;
  // out = parity(sym) ^ state[0]. State and out register on the ctrl pulse.
  logic [STATE_W-1:0] m_state;
  logic               m_out;
  always @(posedge clk) begin
    if (reset) begin
      m_state <= '0;
      m_out   <= 1'b0;
    end else if (fsm_reset) begin
      m_state <= state_init;
      m_out   <= 1'b0;
    end else if (ctrl_out) begin
      m_out   <= (^sw_out) ^ m_state[0];
      m_state <= (sw_out == 2'd0) ? '0 : ((m_state ^ {sw_out, 1'b0}) & 3'b110);
    end
  end
  assign fsm_state = m_state;
  assign fsm_out   = m_out;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; load_valid = 1'b0; clear = 1'b0; start = 1'b0; step_btn = 1'b0;
    tick(2);
    reset = 1'b0;
  endtask

  task automatic load_one(input logic [1:0] s);
    load_valid = 1'b1;
    load_sym   = s;
    tick(1);
    load_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick(1);
    start = 1'b0;
  endtask

  task automatic press_button(output int pulses);
    pulses   = 0;
    step_btn = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick(1);
      if (ctrl_out) pulses++;
    end
    step_btn = 1'b0;
    tick(1);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(2);
    vec_count++;
    if (len !== 4'd0) begin err_count++; $display("[TB] FAIL reset_len: got %0d expected 0", len); end
    vec_count++;
    if (idx !== 4'd0) begin err_count++; $display("[TB] FAIL reset_idx: got %0d expected 0", idx); end
    vec_count++;
    if ({busy, done, ctrl_out, fsm_reset} !== 4'b0000) begin
      err_count++; $display("[TB] FAIL reset_flags: got %b expected 0000", {busy, done, ctrl_out, fsm_reset});
    end
    vec_count++;
    if (out_bits !== 8'h00) begin err_count++; $display("[TB] FAIL reset_out_bits: got %h expected 00", out_bits); end
    vec_count++;
    if ({sw_out, state_init, final_state} !== 8'h00) begin
      err_count++; $display("[TB] FAIL reset_buses: got %h expected 00", {sw_out, state_init, final_state});
    end
    reset = 1'b0;
  endtask

  task automatic test_manual();
    int p;
    do_reset();
    load_one(2'd2); load_one(2'd3); load_one(2'd1); load_one(2'd0);
    init_state = 3'd0;
    step_mode  = 1'b1;
    do_start();
    vec_count++;
    if (fsm_reset !== 1'b1 || busy !== 1'b1) begin
      err_count++; $display("[TB] FAIL manual_init: got fsm_reset=%b busy=%b expected 1 1", fsm_reset, busy);
    end
    tick(1);
    vec_count++;
    if (fsm_reset !== 1'b0) begin err_count++; $display("[TB] FAIL fsm_reset_width: got %b expected 0", fsm_reset); end
    for (int k = 0; k < 4; k++) begin
      press_button(p);
      vec_count++;
      if (p !== 1) begin err_count++; $display("[TB] FAIL manual_pulses step %0d: got %0d expected 1", k, p); end
      if (k < 3) begin
        vec_count++;
        if (idx !== 4'(k + 1)) begin err_count++; $display("[TB] FAIL manual_idx step %0d: got %0d expected %0d", k, idx, k + 1); end
      end
    end
    vec_count++;
    if (out_bits !== 8'b0000_0101) begin err_count++; $display("[TB] FAIL manual_out_bits: got %b expected 00000101", out_bits); end
    vec_count++;
    if (final_state !== 3'd0) begin err_count++; $display("[TB] FAIL manual_final_state: got %0d expected 0", final_state); end
    vec_count++;
    if (done !== 1'b1 || busy !== 1'b0 || len !== 4'd4) begin
      err_count++; $display("[TB] FAIL manual_done: got done=%b busy=%b len=%0d expected 1 0 4", done, busy, len);
    end
  endtask

  task automatic test_auto();
    int         pos [4];
    logic [1:0] sym [4];
    int         n;
    int         exp_pos [3];
    logic [1:0] exp_sym [3];
    exp_pos = '{5, 11, 17};
    exp_sym = '{2'd1, 2'd2, 2'd0};
    n = 0;
    do_reset();
    load_one(2'd1); load_one(2'd2); load_one(2'd0);
    init_state = 3'd1;
    step_mode  = 1'b0;
    do_start();
    vec_count++;
    if (state_init !== 3'd1) begin err_count++; $display("[TB] FAIL auto_state_init: got %0d expected 1", state_init); end
    for (int c = 1; c <= 24; c++) begin
      tick(1);
      if (ctrl_out) begin
        if (n < 4) begin pos[n] = c; sym[n] = sw_out; end
        n++;
      end
    end
    vec_count++;
    if (n !== 3) begin err_count++; $display("[TB] FAIL auto_pulse_count: got %0d expected 3", n); end
    for (int i = 0; i < 3; i++) begin
      vec_count++;
      if (i >= n) begin
        err_count++; $display("[TB] FAIL auto_pulse %0d: missing, expected at cycle %0d", i, exp_pos[i]);
      end else if (pos[i] !== exp_pos[i] || sym[i] !== exp_sym[i]) begin
        err_count++;
        $display("[TB] FAIL auto_pulse %0d: got cycle %0d sym %0d expected cycle %0d sym %0d", i, pos[i], sym[i], exp_pos[i], exp_sym[i]);
      end
    end
    vec_count++;
    if (out_bits !== 8'b0000_0010) begin err_count++; $display("[TB] FAIL auto_out_bits: got %b expected 00000010", out_bits); end
    vec_count++;
    if (final_state !== 3'd0 || done !== 1'b1) begin
      err_count++; $display("[TB] FAIL auto_final: got state=%0d done=%b expected 0 1", final_state, done);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < DEPTH + 2; i++) load_one(2'(i));
    vec_count++;
    if (len !== 4'(DEPTH)) begin err_count++; $display("[TB] FAIL overflow_len: got %0d expected %0d", len, DEPTH); end
    clear = 1'b1; load_valid = 1'b1; load_sym = 2'd1;
    tick(1);
    clear = 1'b0; load_valid = 1'b0;
    vec_count++;
    if (len !== 4'd0) begin err_count++; $display("[TB] FAIL clear_beats_load: got len %0d expected 0", len); end
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(1);
      vec_count++;
      if (busy !== 1'b0 || fsm_reset !== 1'b0) begin
        err_count++; $display("[TB] FAIL empty_start cycle %0d: got busy=%b fsm_reset=%b expected 0 0", c, busy, fsm_reset);
      end
    end
    start = 1'b0;
  endtask

  task automatic test_busy_and_rerun();
    int p;
    do_reset();
    load_one(2'd2); load_one(2'd3); load_one(2'd1); load_one(2'd0);
    init_state = 3'd0;
    step_mode  = 1'b1;
    do_start();
    tick(1);
    start = 1'b1; load_valid = 1'b1; load_sym = 2'd3; clear = 1'b1;
    tick(1);
    start = 1'b0; load_valid = 1'b0; clear = 1'b0;
    vec_count++;
    if (len !== 4'd4 || busy !== 1'b1 || idx !== 4'd0) begin
      err_count++; $display("[TB] FAIL busy_ignore: got len=%0d busy=%b idx=%0d expected 4 1 0", len, busy, idx);
    end
    for (int k = 0; k < 4; k++) press_button(p);
    vec_count++;
    if (out_bits !== 8'b0000_0101) begin err_count++; $display("[TB] FAIL first_run_bits: got %b expected 00000101", out_bits); end
    do_start();
    vec_count++;
    if (out_bits !== 8'h00 || fsm_reset !== 1'b1) begin
      err_count++; $display("[TB] FAIL rerun_init: got out_bits=%b fsm_reset=%b expected 00000000 1", out_bits, fsm_reset);
    end
    tick(1);
    for (int k = 0; k < 4; k++) press_button(p);
    vec_count++;
    if (out_bits !== 8'b0000_0101 || done !== 1'b1) begin
      err_count++; $display("[TB] FAIL rerun_bits: got %b done=%b expected 00000101 1", out_bits, done);
    end
    clear = 1'b1;
    tick(1);
    clear = 1'b0;
    vec_count++;
    if (len !== 4'd0 || done !== 1'b0 || out_bits !== 8'h00) begin
      err_count++; $display("[TB] FAIL done_clear: got len=%0d done=%b out_bits=%b expected 0 0 00000000", len, done, out_bits);
    end
  endtask

  task automatic test_reset_mid_run();
    int p;
    do_reset();
    load_one(2'd2); load_one(2'd3); load_one(2'd1); load_one(2'd0);
    init_state = 3'd0;
    step_mode  = 1'b1;
    do_start();
    tick(1);
    press_button(p);
    press_button(p);
    vec_count++;
    if (out_bits !== 8'b0000_0001) begin err_count++; $display("[TB] FAIL mid_run_bits: got %b expected 00000001", out_bits); end
    step_btn = 1'b1;
    tick(1);
    vec_count++;
    if (ctrl_out !== 1'b1) begin err_count++; $display("[TB] FAIL mid_run_step: got ctrl_out=%b expected 1", ctrl_out); end
    reset = 1'b1;
    tick(1);
    vec_count++;
    if (ctrl_out !== 1'b0 || len !== 4'd0 || out_bits !== 8'h00 || busy !== 1'b0 || fsm_reset !== 1'b0) begin
      err_count++;
      $display("[TB] FAIL mid_run_reset: got ctrl=%b len=%0d bits=%b busy=%b fsm_reset=%b expected 0 0 00000000 0 0",
               ctrl_out, len, out_bits, busy, fsm_reset);
    end
    reset    = 1'b0;
    step_btn = 1'b0;
    tick(1);
  endtask

  initial begin
    test_reset();
    test_manual();
    test_auto();
    test_overflow();
    test_busy_and_rerun();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
